ecc_enc_dec: RTL and testbench



---
 rtl/ecc_pkg.sv | 26 ++
 rtl/ecc_parity_gen.sv | 18 +
 rtl/ecc_enc_dec.sv | 119 +++++++++++
 tb/tb_ecc_enc_dec.sv | 129 ++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared encodings, per-width constants, FSM states and bit-mask helpers for the SECDED core
package ecc_pkg;
  localparam logic [1:0] ENC = 2'd0, DEC = 2'd1, FULL = 2'd2;
  localparam logic [1:0] W8 = 2'd0, W16 = 2'd1, W32 = 2'd2;
  localparam int D8 = 4, D16 = 11, D32 = 26;
  localparam int P8 = 4, P16 = 5, P32 = 6;
  typedef enum logic [1:0] {IDLE, CALC, CALC2, DONE} state_t;
  // Hamming position of data bit j: the non-power-of-two integers from 3 upward
  localparam logic [4:0] DPOS [26] = '{
    5'd3, 5'd5, 5'd6, 5'd7, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15,
    5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26,
    5'd27, 5'd28, 5'd29, 5'd30, 5'd31};
  function automatic int w_of(input logic [1:0] wc);
    return wc == W8 ? 8 : wc == W16 ? 16 : wc == W32 ? 32 : 0;
  endfunction
  function automatic int d_of(input logic [1:0] wc);
    return wc == W8 ? D8 : wc == W16 ? D16 : wc == W32 ? D32 : 0;
  endfunction
  // invalid width yields 1 so that P-1 masks collapse to zero
  function automatic int p_of(input logic [1:0] wc);
    return wc == W8 ? P8 : wc == W16 ? P16 : wc == W32 ? P32 : 1;
  endfunction
  function automatic logic [31:0] lo_mask(input int n);
    return n >= 32 ? 32'hFFFF_FFFF : (32'd1 << n) - 32'd1;
  endfunction
endpackage

// File: rtl/ecc_parity_gen.sv
// ecc_parity_gen: Hamming parities over the data field plus the full-word XOR
// wc_i: width code; word_i: LSB-aligned word; par_o: p_0..p_{P-2} (unused bits 0); ov_o: XOR of word_i[W-1:0]
module ecc_parity_gen
  import ecc_pkg::*;
(
  input  logic [1:0]  wc_i,
  input  logic [31:0] word_i,
  output logic [4:0]  par_o,
  output logic        ov_o
);
  always_comb begin
    par_o = '0;
    for (int j = 0; j < 26; j++)
      for (int i = 0; i < 5; i++)
        if (j < d_of(wc_i) && i < p_of(wc_i) - 1 && DPOS[j][i]) par_o[i] = par_o[i] ^ word_i[j];
    ov_o = ^(word_i & lo_mask(w_of(wc_i)));
  end
endmodule

// File: rtl/ecc_enc_dec.sv
// ecc_enc_dec: SECDED encode / decode / full-channel core with a four-state sequencer
// clk, rst (async active-low), start: request; CTRL, DATA_IN, CODEWORD_WIDTH, NOISE: register values
// data_out: result word; operation_done: one-cycle strobe; num_of_errors: 0/1/2 detected errors
module ecc_enc_dec
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AMBA_WORD-1:0] CTRL,
  input  logic [AMBA_WORD-1:0] DATA_IN,
  input  logic [AMBA_WORD-1:0] CODEWORD_WIDTH,
  input  logic [AMBA_WORD-1:0] NOISE,
  output logic [AMBA_WORD-1:0] data_out,
  output logic                 operation_done,
  output logic [1:0]           num_of_errors
);
  state_t      state_q, state_d;
  logic [1:0]  ctrl_q, ctrl_d, wc_q, wc_d, err_q, err_d, errs_q, errs_d;
  logic [31:0] din_q, din_d, noise_q, noise_d, cw_q, cw_d, res_q, res_d, dout_q, dout_d;
  logic        done_q, done_d;
  logic [31:0] enc_word, enc_pw, cw_enc, dec_word, dec_data;
  logic [4:0]  enc_par, dec_par, recv, syn;
  logic        enc_ov, dec_ov, fix, valid;
  logic [1:0]  dec_err;
  logic        unused_hi;
  assign unused_hi = ^{CTRL, CODEWORD_WIDTH, DATA_IN, NOISE};
  ecc_parity_gen u_enc (.wc_i(wc_q), .word_i(enc_word), .par_o(enc_par), .ov_o(enc_ov));
  ecc_parity_gen u_dec (.wc_i(wc_q), .word_i(dec_word), .par_o(dec_par), .ov_o(dec_ov));
  always_comb begin
    valid    = ctrl_q != 2'd3 && wc_q != 2'd3;
    enc_word = din_q & lo_mask(d_of(wc_q));
    // overall parity sits just above p_0..p_{P-2}
    enc_pw   = 32'(enc_par) | (32'(enc_ov ^ (^enc_par)) << (p_of(wc_q) - 1));
    cw_enc   = enc_word | (enc_pw << d_of(wc_q));
    // second pass of a full-channel run decodes the noisy codeword held in cw_q
    dec_word = (state_q == CALC2 ? cw_q : din_q) & lo_mask(w_of(wc_q));
    recv     = 5'((dec_word >> d_of(wc_q)) & lo_mask(p_of(wc_q) - 1));
    syn      = dec_par ^ recv;
    dec_err  = dec_ov ? 2'd1 : syn != 5'd0 ? 2'd2 : 2'd0;
    // single error at a non-power-of-two position lands on a data bit
    fix      = dec_ov && syn != 5'd0 && (syn & (syn - 5'd1)) != 5'd0;
    dec_data = dec_word & lo_mask(d_of(wc_q));
    for (int j = 0; j < 26; j++)
      if (fix && DPOS[j] == syn) dec_data[j] = ~dec_data[j];
  end
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    wc_d    = wc_q;
    din_d   = din_q;
    noise_d = noise_q;
    cw_d    = cw_q;
    res_d   = res_q;
    err_d   = err_q;
    dout_d  = dout_q;
    errs_d  = errs_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start && !done_q) begin
        ctrl_d  = CTRL[1:0];
        wc_d    = CODEWORD_WIDTH[1:0];
        din_d   = 32'(DATA_IN);
        noise_d = 32'(NOISE);
        state_d = CALC;
      end
      CALC: begin
        res_d   = !valid ? 32'd0 : ctrl_q == ENC ? cw_enc : dec_data;
        err_d   = !valid || ctrl_q == ENC ? 2'd0 : dec_err;
        cw_d    = cw_enc ^ noise_q;
        state_d = valid && ctrl_q == FULL ? CALC2 : DONE;
      end
      CALC2: begin
        res_d   = dec_data;
        err_d   = dec_err;
        state_d = DONE;
      end
      DONE: begin
        dout_d  = res_q;
        errs_d  = err_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      wc_q    <= '0;
      din_q   <= '0;
      noise_q <= '0;
      cw_q    <= '0;
      res_q   <= '0;
      err_q   <= '0;
      dout_q  <= '0;
      errs_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      wc_q    <= wc_d;
      din_q   <= din_d;
      noise_q <= noise_d;
      cw_q    <= cw_d;
      res_q   <= res_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      errs_q  <= errs_d;
      done_q  <= done_d;
    end
  end
  assign data_out       = AMBA_WORD'(dout_q);
  assign operation_done = done_q;
  assign num_of_errors  = errs_q;
endmodule

// File: tb/tb_ecc_enc_dec.sv
// tb_ecc_enc_dec: directed scoreboard bench for the SECDED core
module tb_ecc_enc_dec;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [31:0] ctrl = '0, din = '0, cwr = '0, noise = '0, data_out;
  logic        done;
  logic [1:0]  nerr;
  int          cyc = 0, n_checks = 0, n_fail = 0;
  logic        prev_done = 1'b0;
  typedef struct {logic [31:0] d; logic [1:0] e; bit chk; int at;} exp_t;
  exp_t q[$];

  ecc_enc_dec #(.AMBA_WORD(32)) dut (
    .clk(clk), .rst(rst), .start(start), .CTRL(ctrl), .DATA_IN(din),
    .CODEWORD_WIDTH(cwr), .NOISE(noise), .data_out(data_out),
    .operation_done(done), .num_of_errors(nerr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t x;
    if (done) begin
      check("done_one_cycle", 32'(prev_done), 32'd0);
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: data_out %h errors %0d", data_out, nerr);
      end else begin
        x = q.pop_front();
        if (x.chk) check("data_out", data_out, x.d);
        check("num_of_errors", 32'(nerr), 32'(x.e));
        check("done_cycle", cyc, x.at);
      end
    end
    prev_done = done;
  end

  task automatic issue(input logic [1:0] c, input logic [1:0] w, input logic [31:0] d,
                       input logic [31:0] n, input logic [31:0] ed, input logic [1:0] ee,
                       input bit chk, input int lat);
    @(negedge clk);
    ctrl  = 32'(c);
    cwr   = 32'(w);
    din   = d;
    noise = n;
    start = 1'b1;
    q.push_back('{ed, ee, chk, cyc + 1 + lat});
    @(negedge clk);
    start = 1'b0;
    din   = $urandom;
    noise = $urandom;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("pending_after_timeout", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    logic [31:0] d, n;
    int b1, b2, nb;
    repeat (2) @(negedge clk);
    check("reset_data_out", data_out, 32'd0);
    check("reset_errors", 32'(nerr), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b1;
    issue(2'd0, 2'd0, 32'hB, 32'h0, 32'h1B, 2'd0, 1'b1, 2); drain();
    issue(2'd1, 2'd0, 32'h1A, 32'h0, 32'hB, 2'd1, 1'b1, 2); drain();
    issue(2'd1, 2'd0, 32'hFFFF_FF1B, 32'h0, 32'hB, 2'd0, 1'b1, 2); drain();
    issue(2'd2, 2'd0, 32'hB, 32'h03, 32'h8, 2'd2, 1'b1, 3); drain();
    issue(2'd2, 2'd0, 32'hB, 32'h10, 32'hB, 2'd1, 1'b1, 3); drain();
    issue(2'd0, 2'd1, 32'h1, 32'h0, 32'h9801, 2'd0, 1'b1, 2); drain();
    issue(2'd1, 2'd1, 32'h9800, 32'h0, 32'h1, 2'd1, 1'b1, 2); drain();
    issue(2'd0, 2'd2, 32'h1, 32'h0, 32'h8C00_0001, 2'd0, 1'b1, 2); drain();
    issue(2'd0, 2'd3, 32'hB, 32'h0, 32'h0, 2'd0, 1'b1, 2); drain();
    for (int k = 0; k < 9; k++) begin
      nb = k % 3;
      d  = $urandom & 32'h03FF_FFFF;
      b1 = $urandom_range(0, 31);
      b2 = (b1 + $urandom_range(1, 31)) % 32;
      n  = nb == 0 ? 32'h0 : nb == 1 ? (32'd1 << b1) : ((32'd1 << b1) | (32'd1 << b2));
      issue(2'd2, 2'd2, d, n, d, 2'(nb), nb != 2, 3);
      drain();
    end
    issue(2'd3, 2'd0, 32'h5, 32'h0, 32'h0, 2'd0, 1'b1, 2);
    ctrl  = 32'd0;
    din   = 32'hB;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (6) @(negedge clk);
    issue(2'd1, 2'd0, 32'h1A, 32'h0, 32'hB, 2'd1, 1'b1, 2); drain();
    @(negedge clk);
    ctrl  = 32'd2;
    cwr   = 32'd0;
    din   = 32'hB;
    noise = 32'h3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_data_out", data_out, 32'd0);
    check("rst_mid_errors", 32'(nerr), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    issue(2'd2, 2'd0, 32'hB, 32'h10, 32'hB, 2'd1, 1'b1, 3); drain();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
